// File: rtl/pipeline_drain_buffer.sv
// Credit-controlled drain buffer at the output of a fixed-latency, stall-free pipeline.
// Define PIPELINE_DRAIN_BUFFER_CHECK_EN to compile in the issue-to-result latency checker.
module pipeline_drain_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int LATENCY    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_valid,
   output logic                         issue_ready,
   input  logic                         pipe_valid,
   input  logic [DATA_WIDTH-1:0]        pipe_data,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         overflow_err,
   output logic                         latency_err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [CW-1:0]         used_q, used_d;
   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic full;
   logic issue_fire;
   logic out_fire;
   logic wr_en;

   assign full        = (count_q == CW'(DEPTH));
   assign issue_ready = (used_q < CW'(DEPTH));
   assign out_valid   = (count_q != '0);
   assign out_data    = mem[rd_ptr_q];
   assign occupancy   = used_q;
   assign overflow_err = ovf_q;

   assign issue_fire = issue_valid & issue_ready;
   assign out_fire   = out_valid & out_ready;
   // A full buffer never accepts a write, even if a read frees a slot this cycle.
   assign wr_en      = pipe_valid & ~full;

   always_comb begin
      used_d   = used_q + CW'(issue_fire) - CW'(out_fire);
      count_d  = count_q + CW'(wr_en) - CW'(out_fire);
      wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = out_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
      ovf_d    = ovf_q | (pipe_valid & full);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         used_q   <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         used_q   <= used_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is deliberately not reset; out_data is only meaningful with out_valid.
   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         mem[wr_ptr_q] <= pipe_data;
      end
   end

`ifdef PIPELINE_DRAIN_BUFFER_CHECK_EN
   logic [LATENCY-1:0] issue_sr_q, issue_sr_d;
   logic               lat_err_q, lat_err_d;

   // Bit LATENCY-1 is the issue_fire from exactly LATENCY cycles ago.
   always_comb begin
      issue_sr_d = (issue_sr_q << 1) | LATENCY'(issue_fire);
      lat_err_d  = lat_err_q | (pipe_valid != issue_sr_q[LATENCY-1]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         issue_sr_q <= '0;
         lat_err_q  <= 1'b0;
      end else begin
         issue_sr_q <= issue_sr_d;
         lat_err_q  <= lat_err_d;
      end
   end

   assign latency_err = lat_err_q;
`else
   assign latency_err = 1'b0;
`endif

endmodule

// File: doc/pipeline_drain_buffer.md
# pipeline_drain_buffer

Output end of a fixed-latency, stall-free datapath pipeline (a chain of fixed register delays). It issues credits to the producer side, so no more than DEPTH results are ever in flight or stored. It catches every result the pipeline emits and re-presents results downstream on a valid/ready handshake. This lets the classifier's non-stallable arithmetic pipelines feed back-pressured consumers without losing data.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one pipeline result.
- DEPTH, 8, buffer entries and total credits; ≥2, power of two.
- LATENCY, 4, issue-to-result cycles of the upstream pipeline; used only by the checker (see Configuration).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low; single clock domain.
- issue_valid  in  1  producer launches one operation into the pipeline this cycle.
- issue_ready  out  1  credit available; issue_valid is legal only when this is high.
- pipe_valid  in  1  pipeline output carries a result this cycle.
- pipe_data  in  DATA_WIDTH  pipeline result.
- out_valid  out  1  out_data holds a stored result.
- out_data  out  DATA_WIDTH  oldest stored result (show-ahead).
- out_ready  in  1  consumer accepts out_data.
- occupancy  out  $clog2(DEPTH+1)  credits in use (in flight + stored).
- overflow_err  out  1  sticky: pipe_valid arrived while the buffer was full.
- latency_err  out  1  sticky: result timing mismatch (checker only).

## Operation
- issue_fire = issue_valid & issue_ready. out_fire = out_valid & out_ready.
- Credit counter `used` (0..DEPTH): next = used + issue_fire − out_fire. Simultaneous issue and drain leave it unchanged.
- issue_ready = (used < DEPTH). It is a function of registered state only and never depends on out_ready in the same cycle.
- issue_valid while issue_ready=0 is ignored. The counter does not change.
- Storage is a circular buffer with DEPTH entries. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally. A separate count of stored entries (0..DEPTH) distinguishes full from empty.
- pipe_valid & !full: write mem[wr_ptr] ← pipe_data, then advance wr_ptr. A simultaneous out_fire on a full buffer does not make room in the same cycle; the result is dropped.
- pipe_valid & full: drop the data, set overflow_err. This is impossible when the credit rules are obeyed.
- out_fire: advance rd_ptr. Write and read in the same cycle are both performed.
- out_valid = stored count ≠ 0. out_data = mem[rd_ptr], held stable while out_valid & !out_ready.
- occupancy = used.
- overflow_err and latency_err clear only on reset.

## Timing
- Reset (rst=0 at a posedge) clears used, pointers, stored count and both error flags.
- Outputs after reset: issue_ready=1, out_valid=0, occupancy=0, overflow_err=0, latency_err=0, out_data=don't-care (mem is not reset).
- During a reset cycle, pipe_valid, issue_valid and out_ready are ignored. The upstream pipeline is reset in the same cycle.
- Result write to out_valid: 1 cycle when the buffer is empty. If a write and a read happen in the same cycle on a 1-entry buffer, out_valid stays 1 and the new entry is presented next cycle.
- out_fire to issue_ready: a credit released at posedge N raises issue_ready in cycle N+1.
- Sustained throughput is one result per cycle when out_ready is held high and issue is continuous. used settles at LATENCY+1 when LATENCY+1 ≤ DEPTH.

## Configuration
- PIPELINE_DRAIN_BUFFER_CHECK_EN defined: a LATENCY-deep shift register of issue_fire is compiled in. The register is reset to 0. Each cycle, if pipe_valid ≠ delayed issue_fire, latency_err is set (sticky).
- Not defined: the shift register is absent, latency_err is tied to 0, and LATENCY has no effect.

## Test plan
- Reset, then 8 issues (DEPTH=8, LATENCY=4) with out_ready=0; pipeline returns 8 results 0x10..0x17 -> issue_ready falls after the 8th issue, occupancy=8, out_valid=1 with out_data=0x10, no error flags.
- Full buffer, raise out_ready for 8 cycles -> out_data 0x10..0x17 in order, issue_ready=1 the cycle after the first out_fire, occupancy=0 at the end.
- Continuous issue, out_ready=1, 100 results -> every result out in order, one per cycle in steady state, occupancy constant at 5.
- Write and read on the same cycle with 1 entry stored, plus wrap of pointers past index 7 -> order preserved, out_valid never drops.
- Inject pipe_valid with 0xDEAD while full -> entry dropped, overflow_err=1 and sticky until rst=0, stored data intact.
- With PIPELINE_DRAIN_BUFFER_CHECK_EN, deliver a result at 3 cycles instead of 4 -> latency_err=1. Without the macro -> latency_err stays 0. Assert rst mid-traffic -> all outputs return to their reset values next cycle.
